image_sender: RTL
=================

// Module: image_sender
// PURPOSE
//  Avalon-MM master that drains pixel words to the RS232 UART core, one byte per TX-register write.
//  - Accepts one BYTES*8-bit word on a valid/ready handshake.
//  - Before each byte, polls the UART status register until TX-ready is set.
//  - Bytes go MSB first: the byte-order counterpart of the pixel receive path.
// PARAMETERS
//  BYTES      3      bytes per word; data width is 8*BYTES
//  SYNC_BYTE  8'hA5  header byte, used only when IMAGE_SENDER_SYNC_EN is defined
// PORTS
//  avm_clk          in   1        single clock
//  avm_rst_n        in   1        asynchronous active-low reset
//  avm_address      out  5        Avalon byte address (STATUS_BASE or TX_BASE)
//  avm_read         out  1        Avalon read strobe
//  avm_write        out  1        Avalon write strobe
//  avm_writedata    out  32       {24'b0, byte}
//  avm_readdata     in   32       status word; valid when avm_waitrequest==0
//  avm_waitrequest  in   1        slave stall
//  i_data           in   8*BYTES  word to send
//  i_valid          in   1        i_data valid
//  o_ready          out  1        block accepts a word; transfer = i_valid && o_ready
//  o_busy           out  1        word in flight (state != S_IDLE)
// BEHAVIOUR
//  Reset (async, avm_rst_n=0)
//   - state=S_IDLE, avm_address=STATUS_BASE, avm_read=0, avm_write=0, avm_writedata=0.
//   - byte_cnt=0, hold register=0; o_ready=1 and o_busy=0 (both decoded from state).
//   - Reset mid-transfer aborts the word: no further strobes, and the remaining bytes are lost.
//  Registers
//   - All Avalon outputs come straight from flops; no combinational path from avm_* inputs to avm_* outputs.
//  Avalon rule
//   - read/write are held with a stable address until sampled with avm_waitrequest=0.
//   - avm_readdata is used only in that cycle.
//  FSM
//   S_IDLE
//    - o_ready=1.
//    - On i_valid: latch i_data to hold_r, byte_cnt=0.
//    - Next cycle: avm_read=1, avm_address=STATUS_BASE; go S_CHECK.
//   S_CHECK
//    - If !waitrequest && readdata[TX_OK_BIT]: read=0, write=1, address=TX_BASE, writedata=current byte; go S_SEND.
//    - If !waitrequest && !TX_OK: keep read=1, which re-issues the poll back to back.
//    - If waitrequest: hold everything.
//   S_SEND
//    - On !waitrequest: write=0.
//    - Last byte (byte_cnt==BYTES-1): go S_IDLE.
//    - Otherwise: byte_cnt++, read=1, address=STATUS_BASE, go S_CHECK.
//    - If waitrequest: hold write, address and data.
//  Bytes and width
//   - Current byte = hold_r[8*(BYTES-1-byte_cnt) +: 8], i.e. MSB first.
//   - byte_cnt is $clog2(BYTES+1) bits and never exceeds BYTES-1; there is no wrap.
//  Timing
//   - read and write are never high in the same cycle.
//   - i_data is sampled only on accept; changes while o_ready=0 are ignored.
//   - Minimum latency with zero wait states and TX_OK=1: 2 cycles per byte.
//   - For BYTES=3, o_ready is low for exactly 6 cycles after the accept edge.
// CONFIGURATION
//  IMAGE_SENDER_SYNC_EN defined
//   - Each word is preceded by one SYNC_BYTE transfer, polled like any other byte.
//   - BYTES+1 writes per word; byte_cnt counts 0..BYTES, where 0 selects SYNC_BYTE.
//   - Minimum busy time is 2*(BYTES+1) cycles.
//  IMAGE_SENDER_SYNC_EN undefined
//   - Exactly BYTES writes per word; SYNC_BYTE is unused.
// STRUCTURE
//  image_uart_pkg (shared with the pixel receive path) holds:
//   - RX_BASE=0, TX_BASE=4, STATUS_BASE=8 (byte addresses of the RS232 core registers).
//   - TX_OK_BIT=6, RX_OK_BIT=7.
//   - typedef enum logic [1:0] {S_IDLE,S_CHECK,S_SEND} sender_state_e.
//  No sub-module: the byte select is a one-line indexed part-select in this file.
// TESTING
//  1. Reset released, i_valid=0 for 10 cycles -> read=write=0, o_ready=1, address=8.
//  2. i_data=24'h12_34_56, waitreq=0, status=32'h40 -> writes 0x12,0x34,0x56 to addr 4 in order;
//     o_ready high again 6 cycles after accept.
//  3. Status reads 32'h00 for 5 polls, then 32'h40 -> 5 extra back-to-back reads;
//     the first write happens only after TX_OK.
//  4. waitrequest=1 for 3 cycles during a write of 0x34 -> address=4 and writedata=0x34 stable;
//     exactly one write completes.
//  5. Reset pulsed after the first byte of 24'hAABBCC -> strobes drop at once;
//     after release the next word starts at its MSB.
//  6. IMAGE_SENDER_SYNC_EN, i_data=24'h010203 -> writes 0xA5,0x01,0x02,0x03;
//     o_ready returns after 8 cycles.

Source files
------------

// File: rtl/image_uart_pkg.sv
// Shared register map and state encoding for the RS232 UART pixel send/receive paths.
package image_uart_pkg;

  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] RX_BASE     = 5'd0;
  localparam logic [ADDR_W-1:0] TX_BASE     = 5'd4;
  localparam logic [ADDR_W-1:0] STATUS_BASE = 5'd8;

  localparam int unsigned TX_OK_BIT = 6;
  localparam int unsigned RX_OK_BIT = 7;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SEND} sender_state_e;

endpackage

// File: rtl/image_sender.sv
// Avalon-MM master that streams each accepted word MSB first into the UART TX register.
// Define IMAGE_SENDER_SYNC_EN to prefix every word with one SYNC_BYTE transfer.
module image_sender
  import image_uart_pkg::*;
#(
  parameter int unsigned BYTES     = 3,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                avm_clk,
  input  logic                avm_rst_n,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [31:0]         avm_writedata,
  input  logic [31:0]         avm_readdata,
  input  logic                avm_waitrequest,
  input  logic [8*BYTES-1:0]  i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic                o_busy
);

  localparam int unsigned DW    = 8 * BYTES;
  localparam int unsigned BC_W  = $clog2(BYTES + 1);
  localparam int unsigned IDX_W = (DW > 8) ? $clog2(DW) : 1;
`ifdef IMAGE_SENDER_SYNC_EN
  localparam int unsigned LAST_CNT = BYTES;
`else
  localparam int unsigned LAST_CNT = BYTES - 1;
`endif

  sender_state_e   state;
  logic [DW-1:0]   hold_r;
  logic [BC_W-1:0] byte_cnt;
  logic [IDX_W-1:0] lsb_c;
  logic [7:0]      cur_byte_c;
  logic            last_byte_c;
  logic            unused_bits_c;

  // Byte currently addressed by byte_cnt, MSB first (slot 0 is the header when enabled)
  always_comb begin
    lsb_c      = '0;
    cur_byte_c = '0;
`ifdef IMAGE_SENDER_SYNC_EN
    if (byte_cnt == '0) begin
      cur_byte_c = SYNC_BYTE;
    end else begin
      lsb_c      = IDX_W'(8 * (BYTES - 32'(byte_cnt)));
      cur_byte_c = hold_r[lsb_c +: 8];
    end
`else
    lsb_c      = IDX_W'(8 * (BYTES - 1 - 32'(byte_cnt)));
    cur_byte_c = hold_r[lsb_c +: 8];
`endif
  end

  assign last_byte_c   = (byte_cnt == BC_W'(LAST_CNT));
  assign o_ready       = (state == S_IDLE);
  assign o_busy        = (state != S_IDLE);
  assign unused_bits_c = ^{avm_readdata, SYNC_BYTE};

  // Poll status, then write one byte; repeat until the word is drained
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      state         <= S_IDLE;
      hold_r        <= '0;
      byte_cnt      <= '0;
      avm_address   <= STATUS_BASE;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            hold_r      <= i_data;
            byte_cnt    <= '0;
            avm_read    <= 1'b1;
            avm_address <= STATUS_BASE;
            state       <= S_CHECK;
          end
        end
        S_CHECK: begin
          // A not-ready status leaves read high, which re-polls back to back
          if (!avm_waitrequest && avm_readdata[TX_OK_BIT]) begin
            avm_read      <= 1'b0;
            avm_write     <= 1'b1;
            avm_address   <= TX_BASE;
            avm_writedata <= {24'b0, cur_byte_c};
            state         <= S_SEND;
          end
        end
        S_SEND: begin
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            if (last_byte_c) begin
              avm_address <= STATUS_BASE;
              state       <= S_IDLE;
            end else begin
              byte_cnt    <= byte_cnt + BC_W'(1);
              avm_read    <= 1'b1;
              avm_address <= STATUS_BASE;
              state       <= S_CHECK;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
